// File: rtl/vend_dispenser_if.sv
// Interface bundling the vend request inputs and dispenser status outputs.
// Optional sales_total signal exists only when VEND_SALES_COUNT_EN is defined.
interface vend_dispenser_if #(
  parameter int unsigned STOCK_W = 4
);
  logic [1:0]         vend_code;
  logic               restock;
  logic               motor_a;
  logic               motor_b;
  logic               busy;
  logic               refund;
  logic [STOCK_W-1:0] stock_a;
  logic [STOCK_W-1:0] stock_b;
  logic               empty_a;
  logic               empty_b;
`ifdef VEND_SALES_COUNT_EN
  logic [7:0]         sales_total;
`endif

  // Requester side: issues codes and restock, observes dispenser status.
  modport master (
    output vend_code,
    output restock,
    input  motor_a,
    input  motor_b,
    input  busy,
    input  refund,
    input  stock_a,
    input  stock_b,
    input  empty_a,
`ifdef VEND_SALES_COUNT_EN
    input  sales_total,
`endif
    input  empty_b
  );

  // Dispenser side.
  modport slave (
    input  vend_code,
    input  restock,
    output motor_a,
    output motor_b,
    output busy,
    output refund,
    output stock_a,
    output stock_b,
    output empty_a,
`ifdef VEND_SALES_COUNT_EN
    output sales_total,
`endif
    output empty_b
  );
endinterface

// File: rtl/vend_dispenser.sv
// Product dispenser behind the coin FSM: timed motor pulse per vend, per-product
// stock tracking, one-entry pending slot and refund on rejected requests.
// Optional feature macro: VEND_SALES_COUNT_EN adds a saturating 8-bit sales_total.
module vend_dispenser #(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned STOCK_W      = 4,
  parameter int unsigned STOCK_INIT   = 15
) (
  input logic             clk,
  input logic             reset,
  vend_dispenser_if.slave bus
);

  localparam int unsigned MaxCyc = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned TimerW = $clog2(MaxCyc) + 1;

  typedef enum logic [1:0] {StIdle, StPulse, StGap} state_e;

  state_e             state_q, state_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic               motor_a_q, motor_a_d;
  logic               motor_b_q, motor_b_d;
  logic               refund_q, refund_d;
  logic [STOCK_W-1:0] stock_a_q, stock_a_d;
  logic [STOCK_W-1:0] stock_b_q, stock_b_d;
  // Pending slot: product id (0 = A, 1 = B) plus valid.
  logic               pend_v_q, pend_v_d;
  logic               pend_p_q, pend_p_d;
`ifdef VEND_SALES_COUNT_EN
  logic [7:0]         sales_q, sales_d;
`endif

  logic code_valid;
  logic code_prod;
  logic code_taken;
  logic launch_try;
  logic launch_prod;
  logic launch_ok;

  assign code_valid = (bus.vend_code == 2'b10) || (bus.vend_code == 2'b01);
  assign code_prod  = (bus.vend_code == 2'b01);

  // State, timer, pending slot and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      motor_a_q <= 1'b0;
      motor_b_q <= 1'b0;
      refund_q  <= 1'b0;
      stock_a_q <= STOCK_W'(STOCK_INIT);
      stock_b_q <= STOCK_W'(STOCK_INIT);
      pend_v_q  <= 1'b0;
      pend_p_q  <= 1'b0;
`ifdef VEND_SALES_COUNT_EN
      sales_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      motor_a_q <= motor_a_d;
      motor_b_q <= motor_b_d;
      refund_q  <= refund_d;
      stock_a_q <= stock_a_d;
      stock_b_q <= stock_b_d;
      pend_v_q  <= pend_v_d;
      pend_p_q  <= pend_p_d;
`ifdef VEND_SALES_COUNT_EN
      sales_q   <= sales_d;
`endif
    end
  end

  // Next-state: sequencing, launch arbitration, pending slot, stock and refund.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    motor_a_d   = motor_a_q;
    motor_b_d   = motor_b_q;
    refund_d    = 1'b0;
    stock_a_d   = stock_a_q;
    stock_b_d   = stock_b_q;
    pend_v_d    = pend_v_q;
    pend_p_d    = pend_p_q;
    code_taken  = 1'b0;
    launch_try  = 1'b0;
    launch_prod = 1'b0;
    launch_ok   = 1'b0;
`ifdef VEND_SALES_COUNT_EN
    sales_d     = sales_q;
`endif

    if (bus.vend_code == 2'b11) begin
      refund_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (code_valid) begin
          launch_try  = 1'b1;
          launch_prod = code_prod;
          code_taken  = 1'b1;
        end
      end
      StPulse: begin
        timer_d = timer_q + TimerW'(1);
        if (timer_q == TimerW'(PULSE_CYCLES - 1)) begin
          state_d   = StGap;
          timer_d   = '0;
          motor_a_d = 1'b0;
          motor_b_d = 1'b0;
        end
      end
      StGap: begin
        timer_d = timer_q + TimerW'(1);
        if (timer_q == TimerW'(GAP_CYCLES - 1)) begin
          state_d = StIdle;
          // Pending request has priority; otherwise a code on this cycle bypasses IDLE.
          if (pend_v_q) begin
            launch_try  = 1'b1;
            launch_prod = pend_p_q;
            pend_v_d    = 1'b0;
          end else if (code_valid) begin
            launch_try  = 1'b1;
            launch_prod = code_prod;
            code_taken  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Requests arriving while busy are judged against the slot as it stood this cycle.
    if (code_valid && !code_taken) begin
      if (!pend_v_q) begin
        pend_v_d = 1'b1;
        pend_p_d = code_prod;
      end else begin
        refund_d = 1'b1;
      end
    end

    if (launch_try) begin
      launch_ok = launch_prod ? (stock_b_q != '0) : (stock_a_q != '0);
      if (launch_ok) begin
        state_d   = StPulse;
        timer_d   = '0;
        motor_a_d = !launch_prod;
        motor_b_d = launch_prod;
        if (launch_prod) begin
          stock_b_d = stock_b_q - STOCK_W'(1);
        end else begin
          stock_a_d = stock_a_q - STOCK_W'(1);
        end
`ifdef VEND_SALES_COUNT_EN
        if (sales_q != 8'hFF) begin
          sales_d = sales_q + 8'd1;
        end
`endif
      end else begin
        state_d  = StIdle;
        refund_d = 1'b1;
      end
    end

    // Restock overrides any same-cycle decrement; a running pulse is unaffected.
    if (bus.restock) begin
      stock_a_d = STOCK_W'(STOCK_INIT);
      stock_b_d = STOCK_W'(STOCK_INIT);
    end
  end

  assign bus.motor_a = motor_a_q;
  assign bus.motor_b = motor_b_q;
  assign bus.refund  = refund_q;
  assign bus.stock_a = stock_a_q;
  assign bus.stock_b = stock_b_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.empty_a = (stock_a_q == '0);
  assign bus.empty_b = (stock_b_q == '0);
`ifdef VEND_SALES_COUNT_EN
  assign bus.sales_total = sales_q;
`endif

endmodule

// File: tb/tb_vend_dispenser.sv
// Self-checking bench for vend_dispenser: directed scenarios followed by random
// traffic, all compared each cycle against a countdown/queue reference model.
// Honours VEND_SALES_COUNT_EN when defined.
module tb_vend_dispenser;

  localparam int unsigned P    = 4;
  localparam int unsigned G    = 2;
  localparam int unsigned SW   = 4;
  localparam int unsigned INIT = 2;

  logic clk;
  logic rst_n;

  vend_dispenser_if #(.STOCK_W(SW)) bus ();

  vend_dispenser #(
    .PULSE_CYCLES(P),
    .GAP_CYCLES  (G),
    .STOCK_W     (SW),
    .STOCK_INIT  (INIT)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference model: a dispense occupies P+G cycles counted down in m_remain.
  int m_stock[2];
  int m_remain;
  int m_prod;
  int m_pend[$];
  bit m_refund;
  int m_sales;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int  cand;
    int  had_pend;
    int  p;
    bit  idle;
    bit  taken;
    bit  valid;
    if (!rst_n) begin
      m_stock[0] = INIT;
      m_stock[1] = INIT;
      m_remain   = 0;
      m_pend.delete();
      m_refund   = 0;
      m_sales    = 0;
      m_prod     = 0;
      return;
    end
    m_refund = 0;
    cand     = -1;
    taken    = 0;
    idle     = (m_remain == 0);
    had_pend = m_pend.size();
    valid    = (bus.vend_code == 2'b10) || (bus.vend_code == 2'b01);
    p        = (bus.vend_code == 2'b01) ? 1 : 0;
    if (bus.vend_code == 2'b11) m_refund = 1;
    if (idle) begin
      if (valid) begin
        cand  = p;
        taken = 1;
      end
    end else begin
      if (m_remain == 1) begin
        if (had_pend > 0) cand = m_pend.pop_front();
        else if (valid) begin
          cand  = p;
          taken = 1;
        end
      end
      m_remain--;
    end
    if (valid && !taken) begin
      if (had_pend == 0) m_pend.push_back(p);
      else m_refund = 1;
    end
    if (cand >= 0) begin
      if (m_stock[cand] > 0) begin
        m_stock[cand]--;
        m_remain = P + G;
        m_prod   = cand;
        if (m_sales < 255) m_sales++;
      end else begin
        m_refund = 1;
      end
    end
    if (bus.restock) begin
      m_stock[0] = INIT;
      m_stock[1] = INIT;
    end
  endtask

  task automatic compare_all();
    check("motor_a", 32'(bus.motor_a), 32'((m_remain > G) && (m_prod == 0)));
    check("motor_b", 32'(bus.motor_b), 32'((m_remain > G) && (m_prod == 1)));
    check("busy",    32'(bus.busy),    32'(m_remain > 0));
    check("refund",  32'(bus.refund),  32'(m_refund));
    check("stock_a", 32'(bus.stock_a), 32'(m_stock[0]));
    check("stock_b", 32'(bus.stock_b), 32'(m_stock[1]));
    check("empty_a", 32'(bus.empty_a), 32'(m_stock[0] == 0));
    check("empty_b", 32'(bus.empty_b), 32'(m_stock[1] == 0));
`ifdef VEND_SALES_COUNT_EN
    check("sales_total", 32'(bus.sales_total), 32'(m_sales));
`endif
  endtask

  // One clock: model sees the inputs present at the edge, outputs sampled #1 later.
  task automatic cycle(input logic [1:0] code, input logic rs, input logic rst);
    bus.vend_code = code;
    bus.restock   = rs;
    rst_n         = rst;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  int ma_cnt;
  int busy_cnt;
  int ref_cnt;
  int mb_cnt;
  int sales0;
  logic [1:0] rc;

  initial begin
    vectors     = 0;
    miscompares = 0;
    bus.vend_code = 2'b00;
    bus.restock   = 1'b0;
    rst_n         = 1'b0;
    m_remain = 0;
    m_prod   = 0;
    m_sales  = 0;
    m_refund = 0;
    m_stock[0] = INIT;
    m_stock[1] = INIT;
    @(negedge clk);

    // Reset state.
    cycle(2'b00, 1'b0, 1'b0);
    cycle(2'b00, 1'b0, 1'b0);
    check("reset_stock_a", 32'(bus.stock_a), 32'(INIT));
    check("reset_busy", 32'(bus.busy), 32'd0);

    // 1: single A vend.
    ma_cnt = 0; busy_cnt = 0; ref_cnt = 0;
    cycle(2'b10, 1'b0, 1'b1);
    ma_cnt += int'(bus.motor_a); busy_cnt += int'(bus.busy); ref_cnt += int'(bus.refund);
    for (int i = 0; i < 8; i++) begin
      cycle(2'b00, 1'b0, 1'b1);
      ma_cnt += int'(bus.motor_a); busy_cnt += int'(bus.busy); ref_cnt += int'(bus.refund);
    end
    check("t1_motor_a_cycles", 32'(ma_cnt), 32'd4);
    check("t1_busy_cycles", 32'(busy_cnt), 32'd6);
    check("t1_stock_a", 32'(bus.stock_a), 32'd1);
    check("t1_refunds", 32'(ref_cnt), 32'd0);

    // 2: three B codes one cycle apart; second served from GAP, third refunded.
    busy_cnt = 0; ref_cnt = 0; mb_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      rc = ((i == 0) || (i == 2) || (i == 4)) ? 2'b01 : 2'b00;
      cycle(rc, 1'b0, 1'b1);
      busy_cnt += int'(bus.busy); ref_cnt += int'(bus.refund); mb_cnt += int'(bus.motor_b);
    end
    check("t2_busy_cycles", 32'(busy_cnt), 32'd12);
    check("t2_motor_b_cycles", 32'(mb_cnt), 32'd8);
    check("t2_refunds", 32'(ref_cnt), 32'd1);
    check("t2_stock_b", 32'(bus.stock_b), 32'd0);
    check("t2_empty_b", 32'(bus.empty_b), 32'd1);

    // 3: drain A, then request A with stock 0.
    cycle(2'b10, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(2'b00, 1'b0, 1'b1);
    check("t3_empty_a", 32'(bus.empty_a), 32'd1);
    cycle(2'b10, 1'b0, 1'b1);
    check("t3_refund", 32'(bus.refund), 32'd1);
    check("t3_motor_a", 32'(bus.motor_a), 32'd0);
    check("t3_busy", 32'(bus.busy), 32'd0);
    cycle(2'b00, 1'b0, 1'b1);
    check("t3_refund_single", 32'(bus.refund), 32'd0);

    // 4: illegal code.
    cycle(2'b11, 1'b0, 1'b1);
    check("t4_refund", 32'(bus.refund), 32'd1);
    check("t4_stock_a", 32'(bus.stock_a), 32'd0);
    check("t4_busy", 32'(bus.busy), 32'd0);
    cycle(2'b00, 1'b0, 1'b1);

    // 5: restock, launch A, queue B, reset on second motor cycle.
    cycle(2'b00, 1'b1, 1'b1);
    check("t5_restock_b", 32'(bus.stock_b), 32'(INIT));
    cycle(2'b10, 1'b0, 1'b1);
    cycle(2'b01, 1'b0, 1'b1);
    check("t5_motor_a_2nd", 32'(bus.motor_a), 32'd1);
    cycle(2'b00, 1'b0, 1'b0);
    check("t5_motor_a", 32'(bus.motor_a), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_stock_a", 32'(bus.stock_a), 32'(INIT));
    mb_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(2'b00, 1'b0, 1'b1);
      mb_cnt += int'(bus.motor_b);
    end
    check("t5_pending_cleared", 32'(mb_cnt), 32'd0);

    // 6: restock coinciding with an A launch at stock_a=1.
    cycle(2'b10, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cycle(2'b00, 1'b0, 1'b1);
    check("t6_pre_stock_a", 32'(bus.stock_a), 32'd1);
    sales0 = m_sales;
    ma_cnt = 0;
    cycle(2'b10, 1'b1, 1'b1);
    ma_cnt += int'(bus.motor_a);
    check("t6_stock_a", 32'(bus.stock_a), 32'(INIT));
`ifdef VEND_SALES_COUNT_EN
    check("t6_sales_inc", 32'(bus.sales_total), 32'(sales0 + 1));
`endif
    for (int i = 0; i < 8; i++) begin
      cycle(2'b00, 1'b0, 1'b1);
      ma_cnt += int'(bus.motor_a);
    end
    check("t6_motor_a_cycles", 32'(ma_cnt), 32'd4);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rc = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      cycle(rc, ($urandom_range(0, 29) == 0), ($urandom_range(0, 99) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
